// File: rtl/io_responder.sv
// Memory-mapped IO responder: CPU-side register file in front of a TX byte FIFO
// (drained downstream) and an RX byte FIFO (filled from an incoming strobe).
module io_responder #(
  parameter int unsigned FIFO_AW       = 4,
  parameter int unsigned ALMOST_MARGIN = 2
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rdy_in,
  input  logic       en_in,
  input  logic       wr_in,
  input  logic [2:0] sel_in,
  input  logic [7:0] d_in,
  output logic [7:0] d_out,
  output logic       full_out,
  output logic       finish_out,
  output logic [7:0] tx_data_out,
  output logic       tx_valid_out,
  input  logic       tx_ready_in,
  input  logic [7:0] rx_data_in,
  input  logic       rx_valid_in
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;

  localparam logic [2:0] SEL_DATA   = 3'd0;
  localparam logic [2:0] SEL_STATUS = 3'd1;
  localparam logic [2:0] SEL_FINISH = 3'd4;

  logic [7:0]         tx_mem_q [DEPTH];
  logic [7:0]         tx_mem_d [DEPTH];
  logic [7:0]         rx_mem_q [DEPTH];
  logic [7:0]         rx_mem_d [DEPTH];

  logic [FIFO_AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [FIFO_AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [CW-1:0]      tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic               tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
  logic [7:0]         d_out_q, d_out_d;
  logic               full_q, full_d;
  logic               finish_q, finish_d;

  logic               acc_wr, acc_rd;
  logic               tx_full, tx_empty, rx_full, rx_empty;
  logic               tx_push, tx_drop, tx_pop;
  logic               rx_push, rx_drop, rx_pop;
  logic               status_rd;
  logic [CW-1:0]      tx_free;

  function automatic logic [CW-1:0] next_cnt(input logic [CW-1:0] cnt,
                                             input logic push, input logic pop);
    case ({push, pop})
      2'b10:   return cnt + CW'(1);
      2'b01:   return cnt - CW'(1);
      default: return cnt;
    endcase
  endfunction

  // Access qualification and FIFO events; fullness/emptiness are pre-edge values
  always_comb begin
    acc_wr    = rst_in & rdy_in & en_in & wr_in;
    acc_rd    = rst_in & rdy_in & en_in & ~wr_in;

    tx_full   = (tx_cnt_q == CW'(DEPTH));
    tx_empty  = (tx_cnt_q == '0);
    rx_full   = (rx_cnt_q == CW'(DEPTH));
    rx_empty  = (rx_cnt_q == '0);

    tx_push   = acc_wr & (sel_in == SEL_DATA) & ~tx_full;
    tx_drop   = acc_wr & (sel_in == SEL_DATA) & tx_full;
    tx_pop    = rst_in & ~tx_empty & tx_ready_in;

    rx_push   = rst_in & rx_valid_in & ~rx_full;
    rx_drop   = rst_in & rx_valid_in & rx_full;
    rx_pop    = acc_rd & (sel_in == SEL_DATA) & ~rx_empty;

    status_rd = acc_rd & (sel_in == SEL_STATUS);
    tx_free   = CW'(DEPTH) - tx_cnt_q;
  end

  // TX FIFO next state
  always_comb begin
    tx_mem_d  = tx_mem_q;
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    if (tx_push) begin
      tx_mem_d[tx_wptr_q] = d_in;
      tx_wptr_d           = tx_wptr_q + FIFO_AW'(1);
    end
    if (tx_pop) begin
      tx_rptr_d = tx_rptr_q + FIFO_AW'(1);
    end
    tx_cnt_d = next_cnt(tx_cnt_q, tx_push, tx_pop);
  end

  // RX FIFO next state
  always_comb begin
    rx_mem_d  = rx_mem_q;
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    if (rx_push) begin
      rx_mem_d[rx_wptr_q] = rx_data_in;
      rx_wptr_d           = rx_wptr_q + FIFO_AW'(1);
    end
    if (rx_pop) begin
      rx_rptr_d = rx_rptr_q + FIFO_AW'(1);
    end
    rx_cnt_d = next_cnt(rx_cnt_q, rx_push, rx_pop);
  end

  // Register file: read data, sticky flags, finish and almost-full
  always_comb begin
    d_out_d  = d_out_q;
    finish_d = finish_q;
    full_d   = (tx_free <= CW'(ALMOST_MARGIN));
    // a new overflow on the clearing edge stays visible for the next status read
    tx_ovf_d = (tx_ovf_q & ~status_rd) | tx_drop;
    rx_ovf_d = (rx_ovf_q & ~status_rd) | rx_drop;

    if (acc_rd) begin
      case (sel_in)
        SEL_DATA:   d_out_d = rx_empty ? 8'h00 : rx_mem_q[rx_rptr_q];
        SEL_STATUS: d_out_d = {4'b0000, rx_ovf_q, tx_ovf_q, ~rx_empty, tx_full};
        default:    d_out_d = 8'h00;
      endcase
    end

    if (acc_wr && (sel_in == SEL_FINISH)) begin
      finish_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    tx_mem_q <= tx_mem_d;
    rx_mem_q <= rx_mem_d;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
      tx_ovf_q  <= 1'b0;
      rx_ovf_q  <= 1'b0;
      d_out_q   <= 8'h00;
      full_q    <= 1'b0;
      finish_q  <= 1'b0;
    end else begin
      tx_wptr_q <= tx_wptr_d;
      tx_rptr_q <= tx_rptr_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
      rx_cnt_q  <= rx_cnt_d;
      tx_ovf_q  <= tx_ovf_d;
      rx_ovf_q  <= rx_ovf_d;
      d_out_q   <= d_out_d;
      full_q    <= full_d;
      finish_q  <= finish_d;
    end
  end

  assign d_out        = d_out_q;
  assign full_out     = full_q;
  assign finish_out   = finish_q;
  assign tx_data_out  = tx_mem_q[tx_rptr_q];
  assign tx_valid_out = ~tx_empty;

endmodule

// File: tb/tb_io_responder.sv
// Bench for io_responder: queue-based reference model feeding a per-cycle
// expectation scoreboard, directed scenarios followed by randomized traffic.
module tb_io_responder;

  localparam int DEPTH  = 16;
  localparam int MARGIN = 2;

  logic       clk_in = 1'b0;
  logic       rst_in, rdy_in, en_in, wr_in;
  logic [2:0] sel_in;
  logic [7:0] d_in, d_out, tx_data_out, rx_data_in;
  logic       full_out, finish_out, tx_valid_out, tx_ready_in, rx_valid_in;

  io_responder dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .en_in       (en_in),
    .wr_in       (wr_in),
    .sel_in      (sel_in),
    .d_in        (d_in),
    .d_out       (d_out),
    .full_out    (full_out),
    .finish_out  (finish_out),
    .tx_data_out (tx_data_out),
    .tx_valid_out(tx_valid_out),
    .tx_ready_in (tx_ready_in),
    .rx_data_in  (rx_data_in),
    .rx_valid_in (rx_valid_in)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [7:0] d;
    logic       full;
    logic       fin;
    logic       tv;
    logic [7:0] td;
  } snap_t;

  snap_t      snap_q[$];
  int         n_chk  = 0;
  int         n_fail = 0;

  // Reference model state: contents of each FIFO as plain queues
  logic [7:0] m_tx[$];
  logic [7:0] m_rx[$];
  logic [7:0] m_d;
  logic       m_full, m_fin, m_txo, m_rxo;
  bit         known = 0;
  logic       txr_g = 1'b0;

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares what the DUT presents against the oldest expectation
  always @(negedge clk_in) begin
    if (snap_q.size() > 0) begin
      snap_t s;
      s = snap_q.pop_front();
      chk8("sb_d_out", d_out, s.d);
      chk1("sb_full", full_out, s.full);
      chk1("sb_finish", finish_out, s.fin);
      chk1("sb_tx_valid", tx_valid_out, s.tv);
      if (s.tv) chk8("sb_tx_data", tx_data_out, s.td);
    end
  end

  // Drive one clock of inputs, record this cycle's expectation, advance the model
  task automatic step(input logic rst, input logic rdy, input logic en, input logic wr,
                      input logic [2:0] sel, input logic [7:0] d,
                      input logic rxv, input logic [7:0] rxd);
    snap_t      s;
    logic       acc;
    logic [7:0] status;
    int         pre_tx, pre_rx;
    rst_in = rst; rdy_in = rdy; en_in = en; wr_in = wr; sel_in = sel; d_in = d;
    rx_valid_in = rxv; rx_data_in = rxd; tx_ready_in = txr_g;
    if (known) begin
      s.d    = m_d;
      s.full = m_full;
      s.fin  = m_fin;
      s.tv   = (m_tx.size() != 0);
      s.td   = s.tv ? m_tx[0] : 8'h00;
      snap_q.push_back(s);
    end
    if (!rst) begin
      m_tx.delete(); m_rx.delete();
      m_d = 8'h00; m_full = 1'b0; m_fin = 1'b0; m_txo = 1'b0; m_rxo = 1'b0;
      known = 1;
    end else begin
      pre_tx = m_tx.size();
      pre_rx = m_rx.size();
      acc    = rdy && en;
      status = {4'b0000, m_rxo, m_txo, (pre_rx != 0), (pre_tx == DEPTH)};
      if (acc && !wr) begin
        if (sel == 3'd0)      m_d = (pre_rx != 0) ? m_rx.pop_front() : 8'h00;
        else if (sel == 3'd1) begin m_d = status; m_txo = 1'b0; m_rxo = 1'b0; end
        else                  m_d = 8'h00;
      end
      if (pre_tx != 0 && txr_g) void'(m_tx.pop_front());
      if (acc && wr && sel == 3'd0) begin
        if (pre_tx == DEPTH) m_txo = 1'b1;
        else                 m_tx.push_back(d);
      end
      if (acc && wr && sel == 3'd4) m_fin = 1'b1;
      if (rxv) begin
        if (pre_rx == DEPTH) m_rxo = 1'b1;
        else                 m_rx.push_back(rxd);
      end
      m_full = ((DEPTH - pre_tx) <= MARGIN);
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic wr_bus(input logic [2:0] sel, input logic [7:0] d);
    step(1'b1, 1'b1, 1'b1, 1'b1, sel, d, 1'b0, 8'h00);
  endtask

  task automatic rd_bus(input logic [2:0] sel);
    step(1'b1, 1'b1, 1'b1, 1'b0, sel, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic idle();
    step(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic reset_cyc();
    step(1'b0, 1'b1, 1'b1, 1'b1, 3'd4, 8'hAA, 1'b1, 8'hEE);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    rst_in = 1'b0; rdy_in = 1'b0; en_in = 1'b0; wr_in = 1'b0; sel_in = 3'd0;
    d_in = 8'h00; tx_ready_in = 1'b0; rx_valid_in = 1'b0; rx_data_in = 8'h00;
    @(posedge clk_in);
    #1;

    reset_cyc();
    reset_cyc();
    chk8("reset_d_out", d_out, 8'h00);
    chk1("reset_full", full_out, 1'b0);
    chk1("reset_finish", finish_out, 1'b0);
    chk1("reset_tx_valid", tx_valid_out, 1'b0);

    // Basic TX push and drain
    txr_g = 1'b0;
    wr_bus(3'd0, 8'h41);
    wr_bus(3'd0, 8'h42);
    chk1("tx_valid_two", tx_valid_out, 1'b1);
    chk8("tx_head_41", tx_data_out, 8'h41);
    txr_g = 1'b1;
    idle();
    chk8("tx_head_42", tx_data_out, 8'h42);
    idle();
    chk1("tx_drained", tx_valid_out, 1'b0);
    txr_g = 1'b0;

    // Fill TX, almost-full threshold, overflow and status clear
    for (int i = 0; i < 13; i++) wr_bus(3'd0, 8'(i));
    idle();
    chk1("full_at_13", full_out, 1'b0);
    wr_bus(3'd0, 8'd13);
    idle();
    chk1("full_at_14", full_out, 1'b1);
    for (int i = 14; i < 17; i++) wr_bus(3'd0, 8'(i));
    rd_bus(3'd1);
    chk8("status_ovf", d_out, 8'h05);
    rd_bus(3'd1);
    chk8("status_cleared", d_out, 8'h01);
    txr_g = 1'b1;
    for (int i = 0; i < 18; i++) idle();
    chk1("tx_empty_after_drain", tx_valid_out, 1'b0);
    chk1("full_after_drain", full_out, 1'b0);
    txr_g = 1'b0;

    // RX capture and reads
    step(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 8'h10);
    step(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 8'h20);
    rd_bus(3'd0);
    chk8("rx_read_10", d_out, 8'h10);
    rd_bus(3'd0);
    chk8("rx_read_20", d_out, 8'h20);
    rd_bus(3'd0);
    chk8("rx_read_empty", d_out, 8'h00);

    // Finish flag qualification, hold and reset
    step(1'b1, 1'b0, 1'b1, 1'b1, 3'd4, 8'h00, 1'b0, 8'h00);
    chk1("finish_no_rdy", finish_out, 1'b0);
    wr_bus(3'd4, 8'h00);
    chk1("finish_set", finish_out, 1'b1);
    idle();
    chk1("finish_held", finish_out, 1'b1);
    reset_cyc();
    chk1("finish_reset", finish_out, 1'b0);

    // Mid-operation reset flush
    step(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 8'h55);
    rd_bus(3'd0);
    chk8("d_out_pre_reset", d_out, 8'h55);
    for (int i = 0; i < 3; i++) wr_bus(3'd0, 8'(8'hC0 + i));
    chk1("tx_valid_pre_reset", tx_valid_out, 1'b1);
    reset_cyc();
    chk1("flush_tx_valid", tx_valid_out, 1'b0);
    chk1("flush_full", full_out, 1'b0);
    chk8("flush_d_out", d_out, 8'h00);

    // Read of empty RX coinciding with an incoming byte
    step(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 8'h7F);
    chk8("rx_empty_same_edge", d_out, 8'h00);
    rd_bus(3'd0);
    chk8("rx_stored_7f", d_out, 8'h7F);

    // Randomized traffic: slow drain first so both FIFOs hit their boundaries
    for (int i = 0; i < 3000; i++) begin
      logic       r_rst, r_rdy, r_en, r_wr, r_rxv;
      logic [2:0] r_sel;
      r_rst = ($urandom_range(0, 199) != 0);
      r_rdy = ($urandom_range(0, 3) != 0);
      r_en  = ($urandom_range(0, 1) != 0);
      r_wr  = ($urandom_range(0, 1) != 0);
      r_sel = ($urandom_range(0, 1) != 0) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 7));
      r_rxv = (i < 1500) ? ($urandom_range(0, 1) != 0) : ($urandom_range(0, 3) == 0);
      txr_g = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) != 0);
      step(r_rst, r_rdy, r_en, r_wr, r_sel, 8'($urandom), r_rxv, 8'($urandom));
    end

    txr_g = 1'b0;
    idle();
    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
